prime_power_exponent: RTL and testbench
=======================================

// Module: prime_power_exponent
// PURPOSE
//  Parametrised multi-cycle exponent engine for the Pollard p-1 stage-1 schedule.
//  Computes, for a prime `base` and smoothness bound `bound`, the largest e with
//  base^e <= bound, and also returns base^e.
//  Sits between the prime source and the modular-exponent accumulator.
//  Valid/ready on both sides; one multiply-compare per cycle.
// PARAMETERS
//  BOUND_W  64  width of bound and of power result
//  BASE_W   16  width of base (prime) input
//  EXP_W     8  width of exponent result; exponent saturates at 2^EXP_W-1
// PORTS
//  clk          in   1        clock, all state on rising edge
//  rst_n        in   1        asynchronous active-low reset
//  start_valid  in   1        request present
//  start_ready  out  1        engine can accept (high only in IDLE)
//  bound        in   BOUND_W  smoothness bound B, sampled on start handshake
//  base         in   BASE_W   prime p, sampled on start handshake
//  flush        in   1        synchronous abort to IDLE, any state
//  res_valid    out  1        result held (high only in DONE)
//  res_ready    in   1        consumer accepts result
//  exponent     out  EXP_W    largest e with base^e <= bound
//  power        out  BOUND_W  base^exponent
//  err          out  1        invalid request (base<2 or bound==0)
//  sat          out  1        exponent hit 2^EXP_W-1 before product exceeded bound
// BEHAVIOUR
//  Reset: state=IDLE, start_ready=1, res_valid=0, exponent=0, power=1, err=0, sat=0.
//  States: IDLE, CALC, DONE.
//  IDLE --start_valid&start_ready--> latch bound/base, acc=1, e=0, err=sat=0:
//    - if base<2 or bound==0: err=1, exponent=0, power=1 -> DONE
//      (result visible the cycle after the accept edge).
//    - else -> CALC.
//  CALC, each edge:
//    - nxt = acc*base, full BOUND_W+BASE_W width, no truncation before compare.
//    - if nxt <= bound and e < 2^EXP_W-1: acc=nxt, e=e+1, stay in CALC.
//    - if nxt <= bound and e == 2^EXP_W-1: sat=1 -> DONE.
//    - else -> DONE.
//    - exponent/power outputs track e/acc; valid only when res_valid=1.
//  Latency: accept edge to res_valid = exponent+1 cycles (non-error, non-sat).
//  DONE: outputs stable while res_valid=1 and res_ready=0 (backpressure, any length).
//    - res_valid&res_ready -> IDLE; start_ready rises the next cycle.
//    - No same-cycle result-to-new-start bypass.
//  flush: synchronous; wins over all handshakes in the same cycle.
//    - next state IDLE, res_valid=0, outputs return to reset values.
//  rst_n low mid-CALC or mid-DONE: immediate return to reset values; no result emitted.
//  start_valid while not IDLE: ignored (start_ready=0); bound/base not re-sampled.
//  acc <= bound always holds, so power fits BOUND_W.
//  bound = 2^BOUND_W-1 must not overflow.
// STRUCTURE
//  pollard_pkg: state enum (PPE_IDLE/PPE_CALC/PPE_DONE), default width localparams,
//    shared with the accumulator.
//  One sub-module: ppe_mul_cmp, combinational acc*base and <= bound compare.
//    Kept separate so it can be pipelined later without touching the FSM.
// TESTING
//  1. bound=100, base=3 -> exponent=4, power=81, err=0, sat=0; res_valid 5 cycles after accept.
//  2. bound=81, base=3 -> exponent=4, power=81 (equality counts).
//     bound=80, base=3 -> exponent=3, power=27.
//  3. bound=2^64-1, base=2 -> exponent=63, power=2^63, no overflow.
//     bound=2^64-1, base=65521 -> exponent=4.
//  4. base=1 or base=0 -> err=1, exponent=0, power=1, res_valid 1 cycle after accept.
//     bound=0 -> err=1.
//     bound=1, base=7 -> exponent=0, power=1, err=0.
//  5. EXP_W=3, bound=2^20, base=2 -> exponent=7, power=128, sat=1.
//  6. Handshake and abort:
//     - hold res_ready=0 for 10 cycles -> outputs stable, start_ready=0.
//     - flush mid-CALC -> IDLE next cycle, no res_valid.
//     - rst_n low mid-CALC -> reset values asynchronously.

Source files
------------

// File: rtl/pollard_pkg.sv
// Shared definitions for the Pollard p-1 stage-1 datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pollard_pkg;

  localparam int PPE_BOUND_W = 64;
  localparam int PPE_BASE_W  = 16;
  localparam int PPE_EXP_W   = 8;

  typedef enum logic [1:0] {
    PPE_IDLE = 2'd0,
    PPE_CALC = 2'd1,
    PPE_DONE = 2'd2
  } ppe_state_e;

endpackage

// File: rtl/ppe_mul_cmp.sv
// Combinational acc*base multiply and compare against the bound.
// Latency: 0 cycles (pure combinational; a pipeline stage can be added here later).
// Backpressure: none, the caller decides when to use the result.
module ppe_mul_cmp
  import pollard_pkg::*;
#(
  parameter int BOUND_W = PPE_BOUND_W,
  parameter int BASE_W  = PPE_BASE_W
) (
  input  logic [BOUND_W-1:0] acc,
  input  logic [BASE_W-1:0]  base,
  input  logic [BOUND_W-1:0] bound,
  output logic [BOUND_W-1:0] prod,
  output logic               le
);

  logic [BOUND_W+BASE_W-1:0] full;

  // Full-width product so the compare can never be fooled by wrap-around.
  always_comb begin
    full = {{BASE_W{1'b0}}, acc} * {{BOUND_W{1'b0}}, base};
    le   = (full <= {{BASE_W{1'b0}}, bound});
    prod = full[BOUND_W-1:0];
  end

endmodule

// File: rtl/prime_power_exponent.sv
// Finds the largest e with base^e <= bound and returns e and base^e.
// Latency: exponent+1 cycles from accept to result; error requests complete the cycle after accept.
// Backpressure: start_ready only in IDLE; result held in DONE until res_ready.
module prime_power_exponent
  import pollard_pkg::*;
#(
  parameter int BOUND_W = PPE_BOUND_W,
  parameter int BASE_W  = PPE_BASE_W,
  parameter int EXP_W   = PPE_EXP_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [BOUND_W-1:0] bound,
  input  logic [BASE_W-1:0]  base,
  input  logic               flush,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [EXP_W-1:0]   exponent,
  output logic [BOUND_W-1:0] power,
  output logic               err,
  output logic               sat
);

  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  ppe_state_e         state_q, state_d;
  logic [BOUND_W-1:0] acc_q, acc_d;
  logic [EXP_W-1:0]   e_q, e_d;
  logic [BOUND_W-1:0] bound_q, bound_d;
  logic [BASE_W-1:0]  base_q, base_d;
  logic               err_q, err_d;
  logic               sat_q, sat_d;

  logic [BOUND_W-1:0] prod;
  logic               prod_le;

  ppe_mul_cmp #(
    .BOUND_W (BOUND_W),
    .BASE_W  (BASE_W)
  ) u_mul_cmp (
    .acc   (acc_q),
    .base  (base_q),
    .bound (bound_q),
    .prod  (prod),
    .le    (prod_le)
  );

  // Next-state and datapath update; flush overrides every handshake.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    e_d     = e_q;
    bound_d = bound_q;
    base_d  = base_q;
    err_d   = err_q;
    sat_d   = sat_q;
    if (flush) begin
      state_d = PPE_IDLE;
      acc_d   = BOUND_W'(1);
      e_d     = '0;
      err_d   = 1'b0;
      sat_d   = 1'b0;
    end else begin
      case (state_q)
        PPE_IDLE: begin
          if (start_valid) begin
            bound_d = bound;
            base_d  = base;
            acc_d   = BOUND_W'(1);
            e_d     = '0;
            err_d   = 1'b0;
            sat_d   = 1'b0;
            if ((base < BASE_W'(2)) || (bound == '0)) begin
              err_d   = 1'b1;
              state_d = PPE_DONE;
            end else begin
              state_d = PPE_CALC;
            end
          end
        end
        PPE_CALC: begin
          if (prod_le) begin
            if (e_q != EXP_MAX) begin
              acc_d = prod;
              e_d   = e_q + EXP_W'(1);
            end else begin
              sat_d   = 1'b1;
              state_d = PPE_DONE;
            end
          end else begin
            state_d = PPE_DONE;
          end
        end
        PPE_DONE: begin
          if (res_ready) begin
            state_d = PPE_IDLE;
            acc_d   = BOUND_W'(1);
            e_d     = '0;
            err_d   = 1'b0;
            sat_d   = 1'b0;
          end
        end
        default: state_d = PPE_IDLE;
      endcase
    end
  end

  // State registers with asynchronous reset to the idle/empty result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PPE_IDLE;
      acc_q   <= BOUND_W'(1);
      e_q     <= '0;
      bound_q <= '0;
      base_q  <= '0;
      err_q   <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      e_q     <= e_d;
      bound_q <= bound_d;
      base_q  <= base_d;
      err_q   <= err_d;
      sat_q   <= sat_d;
    end
  end

  // Outputs come straight from state; no combinational path from inputs.
  always_comb begin
    start_ready = (state_q == PPE_IDLE);
    res_valid   = (state_q == PPE_DONE);
    exponent    = e_q;
    power       = acc_q;
    err         = err_q;
    sat         = sat_q;
  end

endmodule

// File: tb/tb_prime_power_exponent.sv
module tb_prime_power_exponent;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [63:0] bound = '0;
  logic [15:0] base = '0;
  logic        flush = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [7:0]  exponent;
  logic [63:0] power;
  logic        err;
  logic        sat;

  logic        b_start_valid = 1'b0;
  logic        b_start_ready;
  logic [63:0] b_bound = '0;
  logic [15:0] b_base = '0;
  logic        b_res_valid;
  logic        b_res_ready = 1'b0;
  logic [2:0]  b_exponent;
  logic [63:0] b_power;
  logic        b_err;
  logic        b_sat;

  int vec_cnt = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  prime_power_exponent dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .bound(bound), .base(base), .flush(flush), .res_valid(res_valid),
    .res_ready(res_ready), .exponent(exponent), .power(power), .err(err), .sat(sat)
  );

  prime_power_exponent #(.BOUND_W(64), .BASE_W(16), .EXP_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start_valid(b_start_valid), .start_ready(b_start_ready),
    .bound(b_bound), .base(b_base), .flush(1'b0), .res_valid(b_res_valid),
    .res_ready(b_res_ready), .exponent(b_exponent), .power(b_power), .err(b_err), .sat(b_sat)
  );

  // Drive one request; returns at the falling edge after the accept edge.
  task automatic start_req(input logic [63:0] bd, input logic [15:0] bs);
    @(negedge clk);
    bound = bd;
    base = bs;
    start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
  endtask

  // Counts rising edges after the accept edge until res_valid is seen (bounded).
  task automatic wait_res(output int edges);
    edges = 0;
    while (!res_valid && edges < 300) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic release_res();
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    vec_cnt++;
    if ({start_ready, res_valid, exponent, power, err, sat} !== {1'b1, 1'b0, 8'd0, 64'd1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset: rdy=%b vld=%b e=%0d p=%0d err=%b sat=%b want 1 0 0 1 0 0",
               start_ready, res_valid, exponent, power, err, sat);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_normal(input string name, input logic [63:0] bd, input logic [15:0] bs,
                             input logic [7:0] exp_e, input logic [63:0] exp_p);
    int edges;
    start_req(bd, bs);
    wait_res(edges);
    vec_cnt++;
    if (edges !== int'(exp_e) + 1) begin
      miscompares++;
      $display("FAIL %s latency: got %0d want %0d", name, edges, int'(exp_e) + 1);
    end
    vec_cnt++;
    if ({exponent, power, err, sat} !== {exp_e, exp_p, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL %s result: e=%0d p=%0d err=%b sat=%b want e=%0d p=%0d err=0 sat=0",
               name, exponent, power, err, sat, exp_e, exp_p);
    end
    release_res();
  endtask

  // Invalid requests: result must already be present in the cycle right after accept.
  task automatic test_err(input string name, input logic [63:0] bd, input logic [15:0] bs);
    int edges;
    start_req(bd, bs);
    wait_res(edges);
    vec_cnt++;
    if (edges !== 0) begin
      miscompares++;
      $display("FAIL %s latency: got %0d extra edges want 0", name, edges);
    end
    vec_cnt++;
    if ({exponent, power, err, sat} !== {8'd0, 64'd1, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL %s result: e=%0d p=%0d err=%b sat=%b want e=0 p=1 err=1 sat=0",
               name, exponent, power, err, sat);
    end
    release_res();
  endtask

  task automatic test_sat();
    int edges;
    @(negedge clk);
    b_bound = 64'd1 << 20;
    b_base = 16'd2;
    b_start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_start_valid = 1'b0;
    edges = 0;
    while (!b_res_valid && edges < 300) begin
      @(negedge clk);
      edges++;
    end
    vec_cnt++;
    if ({b_exponent, b_power, b_err, b_sat} !== {3'd7, 64'd128, 1'b0, 1'b1} || edges !== 8) begin
      miscompares++;
      $display("FAIL sat: e=%0d p=%0d err=%b sat=%b edges=%0d want e=7 p=128 err=0 sat=1 edges=8",
               b_exponent, b_power, b_err, b_sat, edges);
    end
    @(negedge clk);
    b_res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_res_ready = 1'b0;
  endtask

  // Holds the result for 10 cycles while pushing a competing start that must be ignored.
  task automatic test_backpressure();
    int edges;
    int bad;
    start_req(64'd100, 16'd3);
    wait_res(edges);
    bad = 0;
    bound = 64'd1000;
    base = 16'd5;
    start_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ({res_valid, start_ready, exponent, power, err, sat} !== {1'b1, 1'b0, 8'd4, 64'd81, 1'b0, 1'b0})
        bad++;
    end
    start_valid = 1'b0;
    vec_cnt++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL backpressure: %0d unstable cycles want 0 (last e=%0d p=%0d)", bad, exponent, power);
    end
    res_ready = 1'b1;
    vec_cnt++;
    if (start_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL handshake_cycle: start_ready=%b want 0", start_ready);
    end
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    vec_cnt++;
    if ({start_ready, res_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL after_handshake: rdy=%b vld=%b want 1 0", start_ready, res_valid);
    end
  endtask

  task automatic test_flush();
    int seen;
    start_req(64'd100, 16'd3);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    vec_cnt++;
    if ({start_ready, res_valid, exponent, power, err, sat} !== {1'b1, 1'b0, 8'd0, 64'd1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL flush: rdy=%b vld=%b e=%0d p=%0d want 1 0 0 1", start_ready, res_valid, exponent, power);
    end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (res_valid) seen++;
    end
    vec_cnt++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL flush_no_result: res_valid seen %0d cycles want 0", seen);
    end
  endtask

  task automatic test_async_reset();
    start_req(64'd100, 16'd3);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if ({start_ready, res_valid, exponent, power, err, sat} !== {1'b1, 1'b0, 8'd0, 64'd1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL async_reset: rdy=%b vld=%b e=%0d p=%0d want 1 0 0 1", start_ready, res_valid, exponent, power);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] p4;
    logic [63:0] all_ones;
    p4 = 64'd65521 * 64'd65521 * 64'd65521 * 64'd65521;
    all_ones = '1;
    test_reset();
    test_normal("b100_p3", 64'd100, 16'd3, 8'd4, 64'd81);
    test_normal("b81_p3", 64'd81, 16'd3, 8'd4, 64'd81);
    test_normal("b80_p3", 64'd80, 16'd3, 8'd3, 64'd27);
    test_normal("bmax_p2", all_ones, 16'd2, 8'd63, 64'd1 << 63);
    test_normal("bmax_p65521", all_ones, 16'd65521, 8'd4, p4);
    test_normal("b1_p7", 64'd1, 16'd7, 8'd0, 64'd1);
    test_err("base1", 64'd100, 16'd1);
    test_err("base0", 64'd100, 16'd0);
    test_err("bound0", 64'd0, 16'd3);
    test_sat();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_normal("post_reset", 64'd1000, 16'd10, 8'd3, 64'd1000);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
